// File: rtl/front_sprite_line_buffer.sv
// front_sprite_line_buffer
// Ping-pong line buffer behind the front (sprite) layer generator. Sprite pixels
// are drawn into the write bank (~BANK). The read bank (BANK) is streamed to the
// colour mixer and each location is cleared as it is read. Banks swap on LINE_SWAP.
// After reset an init sweep writes CLEAR_VAL to every location in both banks.
// Optional build macros:
//   FRONT_LINEBUF_PRIO_EN : first-drawn wins (2-stage read-modify-write on the write side)
//   FRONT_LINEBUF_FLIP_EN : adds FLIP input, read address becomes ~RD_X when FLIP=1
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | clear sweep over both banks, BUSY=1, all enables ignored
// ST_RUN  | normal write/read/swap operation

module front_sprite_line_buffer #(
    parameter int                ADDR_W    = 9,
    parameter int                DATA_W    = 8,
    parameter logic [2:0]        TRANSP    = 3'h7,
    parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h07
) (
    input  logic              clk,
    input  logic              VIDEO_RSTn,
`ifdef FRONT_LINEBUF_FLIP_EN
    input  logic              FLIP,
`endif
    input  logic              WR_CEN,
    input  logic              LD_X,
    input  logic [8:0]        FL_Y,
    input  logic [DATA_W-1:0] FD,
    input  logic              FD_VALID,
    input  logic              LINE_SWAP,
    input  logic              RD_CEN,
    input  logic [ADDR_W-1:0] RD_X,
    output logic [DATA_W-1:0] PIX_OUT,
    output logic              PIX_OPAQUE,
    output logic              BANK,
    output logic              BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   mem [2][DEPTH];
    logic [DATA_W-1:0]   rd_data;
    logic                run, rd_en, px_take, px_opaque;
    logic                wr_en, wr_bank;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    assign run       = (state_q == ST_RUN);
    assign BUSY      = (state_q == ST_INIT);
    assign rd_en     = run & RD_CEN;
    assign px_take   = run & WR_CEN & ~LD_X & FD_VALID;
    assign px_opaque = (FD[2:0] != TRANSP);
    assign rd_data   = mem[BANK][rd_addr];

`ifdef FRONT_LINEBUF_FLIP_EN
    assign rd_addr = RD_X ^ {ADDR_W{FLIP}};
`else
    assign rd_addr = RD_X;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) state_q <= ST_INIT;
        else             state_q <= state_d;
    end

    // FSM next state: leave INIT once the sweep writes the last address
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (clr_addr == {ADDR_W{1'b1}}) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Init sweep address
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn)  clr_addr <= '0;
        else if (!run)    clr_addr <= clr_addr + 1'b1;
    end

    // Write pointer: load at sprite start, advance on every drawn pixel (opaque or not)
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            wr_ptr <= '0;
        end else if (run && WR_CEN) begin
            if (LD_X)          wr_ptr <= FL_Y[ADDR_W-1:0];
            else if (FD_VALID) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Bank select toggles at line start
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn)            BANK <= 1'b0;
        else if (run && LINE_SWAP)  BANK <= ~BANK;
    end

`ifdef FRONT_LINEBUF_PRIO_EN
    logic              s2_valid, s2_bank, fwd;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_data, s2_old;

    // Stage 2 commits only into a location still holding a transparent code
    assign wr_en   = s2_valid && (s2_old[2:0] == TRANSP);
    assign wr_bank = s2_bank;
    assign wr_addr = s2_addr;
    assign wr_data = s2_data;
    // Stage 2 writing the address stage 1 reads: RAM is stale, take the stage-2 pixel
    assign fwd     = wr_en && (s2_bank == ~BANK) && (s2_addr == wr_ptr);

    // Stage 1 -> stage 2 pipeline control; bank captured so a swap cannot redirect it
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            s2_valid <= 1'b0;
            s2_bank  <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
        end else begin
            s2_valid <= px_take & px_opaque;
            if (px_take && px_opaque) begin
                s2_bank <= ~BANK;
                s2_addr <= wr_ptr;
                s2_data <= FD;
            end
        end
    end

    // Stage 1 read of the stored pixel (kept reset-free so it maps onto RAM output)
    always_ff @(posedge clk) begin
        if (px_take && px_opaque) s2_old <= fwd ? s2_data : mem[~BANK][wr_ptr];
    end
`else
    assign wr_en   = px_take & px_opaque;
    assign wr_bank = ~BANK;
    assign wr_addr = wr_ptr;
    assign wr_data = FD;
`endif

    // Line RAM: init sweep hits both banks, otherwise clear-on-read plus sprite write
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[0][clr_addr] <= CLEAR_VAL;
            mem[1][clr_addr] <= CLEAR_VAL;
        end else begin
            if (rd_en) mem[BANK][rd_addr] <= CLEAR_VAL;
            if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Registered pixel to the colour mixer, holds between read enables
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            PIX_OUT    <= CLEAR_VAL;
            PIX_OPAQUE <= 1'b0;
        end else if (rd_en) begin
            PIX_OUT    <= rd_data;
            PIX_OPAQUE <= (rd_data[2:0] != TRANSP);
        end
    end

endmodule

// File: tb/tb_front_sprite_line_buffer.sv
// Directed bench for front_sprite_line_buffer: init sweep, drawing, wrap,
// overlap, swap timing and mid-line reset.

module tb_front_sprite_line_buffer;

    logic       clk = 1'b0;
    logic       VIDEO_RSTn = 1'b0;
    logic       flip = 1'b0;
    logic       WR_CEN = 1'b0, LD_X = 1'b0, FD_VALID = 1'b0;
    logic       LINE_SWAP = 1'b0, RD_CEN = 1'b0;
    logic [8:0] FL_Y = '0;
    logic [7:0] FD = '0;
    logic [8:0] RD_X = '0;
    logic [7:0] PIX_OUT;
    logic       PIX_OPAQUE, BANK, BUSY;

    int checks = 0;
    int errors = 0;

    front_sprite_line_buffer dut (
        .clk        (clk),
        .VIDEO_RSTn (VIDEO_RSTn),
`ifdef FRONT_LINEBUF_FLIP_EN
        .FLIP       (flip),
`endif
        .WR_CEN     (WR_CEN),
        .LD_X       (LD_X),
        .FL_Y       (FL_Y),
        .FD         (FD),
        .FD_VALID   (FD_VALID),
        .LINE_SWAP  (LINE_SWAP),
        .RD_CEN     (RD_CEN),
        .RD_X       (RD_X),
        .PIX_OUT    (PIX_OUT),
        .PIX_OPAQUE (PIX_OPAQUE),
        .BANK       (BANK),
        .BUSY       (BUSY)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [8:0] y);
        WR_CEN = 1'b1; LD_X = 1'b1; FL_Y = y; FD_VALID = 1'b0;
        tick();
        WR_CEN = 1'b0; LD_X = 1'b0;
    endtask

    task automatic px(input logic [7:0] d);
        WR_CEN = 1'b1; FD_VALID = 1'b1; FD = d;
        tick();
        WR_CEN = 1'b0; FD_VALID = 1'b0;
    endtask

    task automatic swap();
        LINE_SWAP = 1'b1;
        tick();
        LINE_SWAP = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a);
        RD_CEN = 1'b1; RD_X = a;
        tick();
        RD_CEN = 1'b0;
    endtask

    task automatic rd_chk(input logic [8:0] a, input logic [7:0] want, input string tag);
        rd(a);
        chk(tag, PIX_OUT, want);
        chk({tag, "_opq"}, PIX_OPAQUE, (want[2:0] != 3'h7));
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < 600) begin
            tick();
            n++;
        end
        chk(tag, n, 512);
    endtask

    task automatic sweep(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 512; a++) begin
            rd(a[8:0]);
            if (PIX_OUT !== 8'h07 || PIX_OPAQUE !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        logic [7:0] ovl_want;

        // 1. reset values, init sweep length, both banks cleared
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bank", BANK, 1'b0);
        chk("rst_pix", PIX_OUT, 8'h07);
        chk("rst_opq", PIX_OPAQUE, 1'b0);
        chk("rst_busy", BUSY, 1'b1);
        VIDEO_RSTn = 1'b1;
        wait_init("init_len");
        chk("init_busy_low", BUSY, 1'b0);
        sweep("sweep_bank0");
        swap();
        chk("swap1_bank", BANK, 1'b1);
        sweep("sweep_bank1");

        // 2. four pixels from 0x010 including a transparent one
        ld(9'h010);
        px(8'h21); px(8'h27); px(8'h33); px(8'h44);
        swap();
        chk("t2_bank", BANK, 1'b0);
        rd_chk(9'h010, 8'h21, "t2_rd10");
        tick();
        chk("t2_hold", PIX_OUT, 8'h21);
        rd_chk(9'h011, 8'h07, "t2_rd11");
        rd_chk(9'h012, 8'h33, "t2_rd12");
        rd_chk(9'h013, 8'h44, "t2_rd13");
        swap(); swap();
        rd_chk(9'h010, 8'h07, "t2_clr10");
        rd_chk(9'h012, 8'h07, "t2_clr12");
        rd_chk(9'h013, 8'h07, "t2_clr13");

        // 3. write pointer wraps 0x1FF -> 0x000
        ld(9'h1FE);
        px(8'h11); px(8'h12); px(8'h13); px(8'h14);
        swap();
        rd_chk(9'h1FE, 8'h11, "t3_1fe");
        rd_chk(9'h1FF, 8'h12, "t3_1ff");
        rd_chk(9'h000, 8'h13, "t3_000");
        rd_chk(9'h001, 8'h14, "t3_001");

        // 4. overlapping sprites at 0x080
        ld(9'h080); px(8'h15);
        ld(9'h080); px(8'h26);
        swap();
        tick();
`ifdef FRONT_LINEBUF_PRIO_EN
        ovl_want = 8'h15;
`else
        ovl_want = 8'h26;
`endif
        rd_chk(9'h080, ovl_want, "t4_overlap");

        // 5. pixel coincident with swap lands in the pre-swap write bank
        chk("t5_bank_pre", BANK, 1'b0);
        ld(9'h020);
        WR_CEN = 1'b1; FD_VALID = 1'b1; FD = 8'h52; LINE_SWAP = 1'b1;
        tick();
        WR_CEN = 1'b0; FD_VALID = 1'b0; LINE_SWAP = 1'b0;
        chk("t5_bank_post", BANK, 1'b1);
        tick();
        rd_chk(9'h020, 8'h52, "t5_rd20");

        // 6. asynchronous reset mid-line while writing
        ld(9'h030); px(8'h61); px(8'h62);
        WR_CEN = 1'b1; FD_VALID = 1'b1; FD = 8'h63;
        #2;
        VIDEO_RSTn = 1'b0;
        #1;
        chk("t6_rst_bank", BANK, 1'b0);
        chk("t6_rst_pix", PIX_OUT, 8'h07);
        chk("t6_rst_opq", PIX_OPAQUE, 1'b0);
        chk("t6_rst_busy", BUSY, 1'b1);
        @(posedge clk);
        #1;
        LINE_SWAP = 1'b1; RD_CEN = 1'b1; RD_X = 9'h030;
        VIDEO_RSTn = 1'b1;
        wait_init("t6_init_len");
        WR_CEN = 1'b0; FD_VALID = 1'b0; LINE_SWAP = 1'b0; RD_CEN = 1'b0;
        chk("t6_init_noswap", BANK, 1'b0);
        chk("t6_init_noread", PIX_OUT, 8'h07);
        rd_chk(9'h030, 8'h07, "t6_gone30");
        rd_chk(9'h031, 8'h07, "t6_gone31");
        px(8'h45);
        swap();
        tick();
        rd_chk(9'h000, 8'h45, "t6_wrptr0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
